// File: rtl/rpsc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rpsc_pkg                                                                   |
// | Shared channel indices and FSM states for the RPSC interlock conditioner.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rpsc_pkg;

  localparam int N_CH = 7;

  typedef enum logic [2:0] {
    CH_CARD_POS    = 3'd0,
    CH_AIR_GRID    = 3'd1,
    CH_WATER_ANODE = 3'd2,
    CH_WATER_GRID  = 3'd3,
    CH_DC_PS       = 3'd4,
    CH_U_CA_LOW    = 3'd5,
    CH_I_CA_HIGH   = 3'd6
  } rpsc_ch_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_TRIP  = 2'd1,
    ST_CLEAR = 2'd2
  } rpsc_state_e;

endpackage
`default_nettype wire

// File: rtl/rpsc_debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rpsc_debounce_ch                                                           |
// | Two-flop synchroniser followed by a consecutive-cycle debounce counter.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rpsc_debounce_ch
  import rpsc_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic deb_o
);

  localparam int             c_cnt_w  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEB_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_deb;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw_i;
      r_sync2 <= r_sync1;
      // A change is accepted only after DEB_CYCLES consecutive disagreeing samples
      if (r_sync2 != r_deb) begin
        if (r_cnt == c_last) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_one;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign deb_o = r_deb;

endmodule
`default_nettype wire

// File: rtl/rpsc_interlock_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rpsc_interlock_conditioner                                                 |
// | Debounces and latches RPSC interlocks; first-fault, ack handshake, trips.  |
// | Optional channel bypass mask: RPSC_FAULT_BYPASS_EN.                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rpsc_interlock_conditioner
  import rpsc_pkg::*;
#(
  parameter int N_CH       = rpsc_pkg::N_CH,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  raw_fault_i,
  input  logic             ack_i,
  output logic [N_CH-1:0]  status_o,
  output logic             not_alarm_o,
  output logic [N_CH-1:0]  first_fault_o,
  output logic             tripped_o,
  output logic             ack_reject_o,
  output logic [CNT_W-1:0] trip_count_o
`ifdef RPSC_FAULT_BYPASS_EN
  ,
  input  logic [N_CH-1:0]  bypass_mask_i,
  output logic             bypass_active_o
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [N_CH-1:0]  w_deb;
  logic [N_CH-1:0]  w_mask;
  logic [N_CH-1:0]  w_deb_eff;
  logic             w_any;
  logic             w_ack_rise;

  rpsc_state_e      r_state;
  rpsc_state_e      w_state_nxt;
  logic [N_CH-1:0]  r_status;
  logic [N_CH-1:0]  w_status_nxt;
  logic [N_CH-1:0]  r_first;
  logic [N_CH-1:0]  w_first_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_ack_d;
  logic             r_ack_reject;
  logic             w_ack_reject_nxt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rpsc_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw_i (raw_fault_i[g]),
      .deb_o (w_deb[g])
    );
  end

`ifdef RPSC_FAULT_BYPASS_EN
  assign w_mask          = bypass_mask_i;
  assign bypass_active_o = |bypass_mask_i;
`else
  assign w_mask          = '0;
`endif

  // Masked channels keep debouncing but are invisible to latching and the FSM
  assign w_deb_eff  = w_deb & ~w_mask;
  assign w_any      = |w_deb_eff;
  assign w_ack_rise = ack_i & ~r_ack_d;

  always_comb begin
    w_state_nxt      = r_state;
    w_status_nxt     = (r_status | w_deb_eff) & ~w_mask;
    w_first_nxt      = r_first;
    w_count_nxt      = r_count;
    w_ack_reject_nxt = 1'b0;
    unique case (r_state)
      ST_OK: begin
        if (w_any) begin
          w_state_nxt = ST_TRIP;
          w_first_nxt = w_deb_eff;
          if (r_count != c_cnt_max) begin
            w_count_nxt = r_count + c_cnt_one;
          end
        end
      end
      ST_TRIP: begin
        if (w_ack_rise) begin
          if (w_any) begin
            w_ack_reject_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        w_state_nxt  = ST_OK;
        w_status_nxt = '0;
        w_first_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_OK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_OK;
      r_status     <= '0;
      r_first      <= '0;
      r_count      <= '0;
      r_ack_d      <= 1'b0;
      r_ack_reject <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_status     <= w_status_nxt;
      r_first      <= w_first_nxt;
      r_count      <= w_count_nxt;
      r_ack_d      <= ack_i;
      r_ack_reject <= w_ack_reject_nxt;
    end
  end

  assign status_o      = r_status;
  assign not_alarm_o   = ~|r_status;
  assign first_fault_o = r_first;
  assign tripped_o     = (r_state == ST_TRIP);
  assign ack_reject_o  = r_ack_reject;
  assign trip_count_o  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rpsc_interlock_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rpsc_interlock_conditioner                                              |
// | Directed scenarios plus random stimulus against a window-based model.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rpsc_interlock_conditioner;

  localparam int DEB = 16;

  logic       clk;
  logic       reset;
  logic [6:0] raw;
  logic       ack;
  logic [6:0] status_o;
  logic       not_alarm_o;
  logic [6:0] first_fault_o;
  logic       tripped_o;
  logic       ack_reject_o;
  logic [7:0] trip_count_o;

  int n_total = 0;
  int n_bad   = 0;

  rpsc_interlock_conditioner #(
    .N_CH       (7),
    .DEB_CYCLES (DEB),
    .CNT_W      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_fault_i   (raw),
    .ack_i         (ack),
    .status_o      (status_o),
    .not_alarm_o   (not_alarm_o),
    .first_fault_o (first_fault_o),
    .tripped_o     (tripped_o),
    .ack_reject_o  (ack_reject_o),
    .trip_count_o  (trip_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: raw history gives the synchronised sample; a channel's debounced
  // value flips once the last DEB synchronised samples all disagree with it.
  logic [6:0] raw_q[$];
  logic [6:0] syn_q[$];
  logic [6:0] deb_m, st_m, ff_m;
  int         mode_m;  // 0 OK, 1 TRIP, 2 CLEAR
  int         cnt_m;
  bit         rej_m, ack_pm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    syn_q.delete();
    deb_m = '0; st_m = '0; ff_m = '0;
    mode_m = 0; cnt_m = 0; rej_m = 1'b0; ack_pm = 1'b0;
  endtask

  task automatic model_step();
    logic [6:0] s2p, deb_n;
    bit rise, anyd, all_diff;
    int mode_pre;
    s2p = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 7'd0;
    raw_q.push_back(raw);
    if (raw_q.size() > 2) void'(raw_q.pop_front());
    syn_q.push_back(s2p);
    if (syn_q.size() > DEB) void'(syn_q.pop_front());
    deb_n = deb_m;
    for (int ch = 0; ch < 7; ch++) begin
      if (syn_q.size() == DEB) begin
        all_diff = 1'b1;
        foreach (syn_q[j]) if (syn_q[j][ch] == deb_m[ch]) all_diff = 1'b0;
        if (all_diff) deb_n[ch] = ~deb_m[ch];
      end
    end
    rise = ack && !ack_pm;
    ack_pm = ack;
    anyd = |deb_m;
    mode_pre = mode_m;
    rej_m = (mode_pre == 1) && rise && anyd;
    st_m = (mode_pre == 2) ? 7'd0 : (st_m | deb_m);
    case (mode_pre)
      0: if (anyd) begin
           mode_m = 1;
           ff_m = deb_m;
           if (cnt_m < 255) cnt_m++;
         end
      1: if (rise && !anyd) mode_m = 2;
      default: begin
           mode_m = 0;
           ff_m = '0;
         end
    endcase
    deb_m = deb_n;
  endtask

  task automatic compare_all();
    chk("status",    32'(status_o),      32'(st_m));
    chk("not_alarm", 32'(not_alarm_o),   32'(st_m == 7'd0));
    chk("first",     32'(first_fault_o), 32'(ff_m));
    chk("tripped",   32'(tripped_o),     32'(mode_m == 1));
    chk("reject",    32'(ack_reject_o),  32'(rej_m));
    chk("count",     32'(trip_count_o),  32'(cnt_m));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    reset = 1'b0;
    raw   = '0;
    ack   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_status",    32'(status_o),      32'd0);
    chk("rst_not_alarm", 32'(not_alarm_o),   32'd1);
    chk("rst_tripped",   32'(tripped_o),     32'd0);
    chk("rst_count",     32'(trip_count_o),  32'd0);
    reset = 1'b1;

    cyc(100);
    chk("idle_status",   32'(status_o),      32'd0);
    chk("idle_count",    32'(trip_count_o),  32'd0);

    // Short glitch on AIR_GRID is filtered
    raw[1] = 1'b1;
    cyc(10);
    raw = '0;
    cyc(24);
    chk("glitch_status",  32'(status_o),  32'd0);
    chk("glitch_tripped", 32'(tripped_o), 32'd0);

    // WATER_ANODE held: trip exactly 2+16+1 cycles later
    raw[2] = 1'b1;
    cyc(18);
    chk("wa_early_trip", 32'(tripped_o), 32'd0);
    cyc(1);
    chk("wa_trip",   32'(tripped_o),     32'd1);
    chk("wa_status", 32'(status_o),      32'b0000100);
    chk("wa_first",  32'(first_fault_o), 32'b0000100);
    chk("wa_count",  32'(trip_count_o),  32'd1);
    ack = 1'b1;
    cyc(1);
    chk("ack_reject_pulse", 32'(ack_reject_o), 32'd1);
    cyc(1);
    chk("ack_reject_end",   32'(ack_reject_o), 32'd0);
    chk("ack_reject_trip",  32'(tripped_o),    32'd1);
    raw = '0;
    cyc(18);
    ack = 1'b0;
    cyc(1);
    ack = 1'b1;
    cyc(1);
    chk("clear_state",  32'(tripped_o),   32'd0);
    cyc(1);
    chk("clear_status", 32'(status_o),    32'd0);
    chk("clear_alarm",  32'(not_alarm_o), 32'd1);
    ack = 1'b0;
    cyc(2);

    // DC_PS and I_CA_HIGH together
    raw = 7'b1010000;
    cyc(19);
    chk("dual_first", 32'(first_fault_o), 32'b1010000);
    chk("dual_count", 32'(trip_count_o),  32'd2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) raw[$urandom_range(0, 6)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) raw = '0;
      if ($urandom_range(0, 7) == 0) ack = ~ack;
      cyc(1);
    end

    // Force a trip, then reset asynchronously between clock edges
    raw = 7'b0001000;
    ack = 1'b0;
    cyc(22);
    chk("pre_async_trip", 32'(tripped_o), 32'd1);
    @(posedge clk);
    model_step();
    #3 reset = 1'b0;
    #1;
    chk("async_status", 32'(status_o),      32'd0);
    chk("async_alarm",  32'(not_alarm_o),   32'd1);
    chk("async_first",  32'(first_fault_o), 32'd0);
    chk("async_trip",   32'(tripped_o),     32'd0);
    chk("async_count",  32'(trip_count_o),  32'd0);
    model_reset();
    raw = '0;
    @(negedge clk);
    compare_all();
    reset = 1'b1;

    for (int t = 0; t < 300; t++) begin
      raw = 7'b0000001;
      cyc(19);
      raw = '0;
      cyc(18);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      cyc(2);
    end
    chk("sat_count", 32'(trip_count_o), 32'd255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rpsc_interlock_conditioner.md
Name: rpsc_interlock_conditioner

Overview:
- Conditioning stage directly upstream of the RPSC card-1 permission logic.
- Synchronises, debounces and latches the seven status/interlock inputs: Card_POS, Air_Grid, Water_Anode, Water_Grid, DC_PS, U_CA_Low, I_CA_High.
- Outputs latched active-high fault bits, which feed the card's status NOR and alarm path.
- Adds first-fault capture, operator acknowledge handshake and trip counting.

Parameters:
- N_CH, 7, number of interlock channels; bit order per package channel enum.
- DEB_CYCLES, 16, consecutive stable cycles required to accept a level change (250 ms at the 64 Hz system tick).
- CNT_W, 8, width of saturating trip counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- raw_fault_i  input  N_CH  unsynchronised interlock inputs; 1 = fault.
- ack_i  input  1  operator acknowledge, level; acted on at its rising edge.
- status_o  output  N_CH  latched fault bits to downstream card.
- not_alarm_o  output  1  1 when no latched fault (~|status_o).
- first_fault_o  output  N_CH  channel(s) that caused the current trip.
- tripped_o  output  1  FSM in TRIP.
- ack_reject_o  output  1  one-cycle pulse: ack refused because a debounced fault is still present.
- trip_count_o  output  CNT_W  saturating count of OK->TRIP transitions.

Behaviour:
- Reset (reset=0, async): synchroniser flops, debounced values, counters, latches, first_fault_o, trip_count_o and ack edge flop all 0. FSM = OK, not_alarm_o=1, other outputs 0. Reset mid-operation discards all latched state immediately.
- Synchroniser: 2 flops per channel.
- Debounce, per channel:
  - Counter increments while synced value != debounced value; cleared when they agree.
  - When counter reaches DEB_CYCLES-1 and still differs, debounced value toggles and counter clears.
  - Latency raw -> debounced = 2 + DEB_CYCLES cycles. A glitch shorter than DEB_CYCLES cycles has no effect.
- Latch: status_o[i] is set in the cycle after deb[i]=1. It is cleared only in CLEAR state.
- FSM states OK, TRIP, CLEAR:
  - OK -> TRIP when any deb bit = 1. In that transition, first_fault_o is loaded with the set deb bits; simultaneous faults set multiple bits. trip_count_o increments, saturating at 2^CNT_W-1.
  - TRIP:
    - On ack rising edge with all deb = 0 -> CLEAR.
    - On ack rising edge with any deb = 1 -> stay in TRIP and pulse ack_reject_o for 1 cycle.
    - New faults while in TRIP set further status_o bits; first_fault_o does not change.
  - CLEAR (1 cycle): status_o and first_fault_o <= 0, then -> OK. If a deb bit rises during CLEAR, the OK->TRIP check in the next cycle re-trips.
- Held ack: a held-high ack_i produces only one edge; a fresh trip needs a new rising edge.
- not_alarm_o and tripped_o are registered-state derived and glitch-free.

Optional Feature:
- RPSC_FAULT_BYPASS_EN: adds input bypass_mask_i[N_CH].
  - Masked channels are forced to deb=0 for latching, trip detection and the ack check.
  - status_o bit is 0 for masked channels; the raw debounce still runs.
  - Adds output bypass_active_o = |bypass_mask_i.
- Without the macro: no extra ports; mask is constant 0.

Decomposition:
- Package rpsc_pkg:
  - N_CH localparam.
  - Channel index enum: CH_CARD_POS=0, CH_AIR_GRID, CH_WATER_ANODE, CH_WATER_GRID, CH_DC_PS, CH_U_CA_LOW, CH_I_CA_HIGH.
  - FSM state enum {ST_OK, ST_TRIP, ST_CLEAR}.
- Sub-module rpsc_debounce_ch: 2-flop synchroniser + counter for one channel, parameter DEB_CYCLES. Instantiated N_CH times via generate.

Test Plan:
- Reset, then raw_fault_i=0 for 100 cycles -> not_alarm_o=1, status_o=0, trip_count_o=0.
- 10-cycle pulse on CH_AIR_GRID -> no debounce change; status_o stays 0, tripped_o stays 0.
- CH_WATER_ANODE held high -> status_o[2]=1 and tripped_o=1 at cycle 2+16+1. first_fault_o=7'b0000100, trip_count_o=1.
- CH_DC_PS and CH_I_CA_HIGH rise in the same cycle -> first_fault_o=7'b1010000 (bits 4 and 6).
- Fault still present, ack_i rising edge -> ack_reject_o pulses 1 cycle, state stays TRIP. Remove fault, wait 18 cycles, ack again -> CLEAR 1 cycle, then status_o=0, not_alarm_o=1.
- Assert reset=0 asynchronously mid-TRIP -> all outputs 0 and not_alarm_o=1 without waiting for a clock edge. Trip 300 times -> trip_count_o saturates at 255.
